vga_sync_monitor: RTL and testbench

- Receive-side counterpart to the team's VGA timing generator: samples HS/VS and the 1-bit RGB lines and recovers the pixel coordinates.
- Measures line and frame timing, declares lock against the expected mode, and counts timing errors.
- Runs on the same pixel clock as the generator. Used as an on-chip loopback checker and as the front end for frame-capture logic.

---
 rtl/vga_sync_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from HS/VS/RGB,
// measures line/frame timing, tracks lock against the expected mode and counts lock losses.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_START = 144,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_START = 35,
    parameter int unsigned V_VIS   = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_n,
    input  logic       vs_n,
    input  logic       r_in,
    input  logic       g_in,
    input  logic       b_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       pix_r,
    output logic       pix_g,
    output logic       pix_b,
    output logic       frame_start,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       err_pulse,
    output logic [7:0] err_cnt
);

    localparam int unsigned CW  = 10;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned EW  = 8;

    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [EW-1:0]  ERR_MAX = '1;
    localparam logic [CW-1:0]  H_LO    = CW'(H_START);
    localparam logic [CW-1:0]  H_HI    = CW'(H_START + H_VIS);
    localparam logic [CW-1:0]  V_LO    = CW'(V_START);
    localparam logic [CW-1:0]  V_HI    = CW'(V_START + V_VIS);
    localparam logic [CW1-1:0] H_TOT   = CW1'(H_TOTAL);
    localparam logic [CW1-1:0] V_TOT   = CW1'(V_TOTAL);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic          hs_q, vs_q, r_q, g_q, b_q;
    logic          hs_prev_q, vs_prev_q;
    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          h_seen_q, h_seen_d;
    logic          bad_q, bad_d;

    logic [CW-1:0] pix_x_q, pix_x_d;
    logic [CW-1:0] pix_y_q, pix_y_d;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_r_q, pix_r_d;
    logic          pix_g_q, pix_g_d;
    logic          pix_b_q, pix_b_d;
    logic          frame_start_q, frame_start_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] line_len_q, line_len_d;
    logic [CW-1:0] frame_lines_q, frame_lines_d;
    logic          err_pulse_q, err_pulse_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;

    logic           hs_edge, vs_edge;
    logic [CW1-1:0] h_meas, v_meas;
    logic           line_bad, lines_ok, h_sat, v_sat, lose, in_win;

    assign hs_edge  = hs_prev_q & ~hs_q;
    assign vs_edge  = vs_prev_q & ~vs_q;
    assign h_meas   = {1'b0, h_cnt_q} + CW1'(1);
    assign v_meas   = {1'b0, v_cnt_q} + CW1'(hs_edge);
    assign line_bad = hs_edge & h_seen_q & (h_meas != H_TOT);
    assign lines_ok = (v_meas == V_TOT);
    assign h_sat    = (h_cnt_q == CNT_MAX);
    assign v_sat    = (v_cnt_q == CNT_MAX);

    // Counters and measurements; a VS edge coincident with HS counts that line once.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_seen_d      = h_seen_q | hs_edge;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (hs_edge) begin
            h_cnt_d    = '0;
            line_len_d = h_meas[CW] ? CNT_MAX : h_meas[CW-1:0];
        end else if (!h_sat) begin
            h_cnt_d = h_cnt_q + CW'(1);
        end
        if (vs_edge) begin
            v_cnt_d       = '0;
            frame_lines_d = v_meas[CW] ? CNT_MAX : v_meas[CW-1:0];
        end else if (hs_edge && !v_sat) begin
            v_cnt_d = v_cnt_q + CW'(1);
        end
    end

    // Lock FSM next-state and error/frame pulses.
    always_comb begin
        state_d       = state_q;
        bad_d         = bad_q;
        err_pulse_d   = 1'b0;
        err_cnt_d     = err_cnt_q;
        frame_start_d = 1'b0;
        lose          = 1'b0;
        case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d = MEASURE;
                    bad_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (h_sat) begin
                    state_d = SEARCH;
                end else if (vs_edge) begin
                    if (!bad_q && !line_bad && lines_ok) begin
                        state_d = LOCKED;
                    end
                    bad_d = 1'b0;
                end else if (line_bad) begin
                    bad_d = 1'b1;
                end
            end
            LOCKED: begin
                lose = line_bad | (vs_edge & ~lines_ok) | h_sat | v_sat;
                if (lose) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + EW'(1);
                    end
                    state_d = (h_sat || v_sat) ? SEARCH : MEASURE;
                    // A loss mid-frame taints the rest of that frame for re-measurement.
                    bad_d   = ~vs_edge;
                end else begin
                    frame_start_d = vs_edge;
                end
            end
            default: begin
                state_d = SEARCH;
                bad_d   = 1'b0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // Pixel stage: next counter values line up with the stage-1 colour sample.
    always_comb begin
        in_win      = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                      (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
        pix_valid_d = locked_q & in_win;
        pix_x_d     = '0;
        pix_y_d     = '0;
        pix_r_d     = 1'b0;
        pix_g_d     = 1'b0;
        pix_b_d     = 1'b0;
        if (pix_valid_d) begin
            pix_x_d = h_cnt_d - H_LO;
            pix_y_d = v_cnt_d - V_LO;
            pix_r_d = r_q;
            pix_g_d = g_q;
            pix_b_d = b_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            r_q           <= 1'b0;
            g_q           <= 1'b0;
            b_q           <= 1'b0;
            state_q       <= SEARCH;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_seen_q      <= 1'b0;
            bad_q         <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            pix_r_q       <= 1'b0;
            pix_g_q       <= 1'b0;
            pix_b_q       <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            hs_q          <= hs_n;
            vs_q          <= vs_n;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            r_q           <= r_in;
            g_q           <= g_in;
            b_q           <= b_in;
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_seen_q      <= h_seen_d;
            bad_q         <= bad_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            err_pulse_q   <= err_pulse_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign err_pulse   = err_pulse_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 10x8 timing mode
// (HS 2 clocks, VS 2 lines, 6x5 visible window at column 3 / line 2).
module tb_vga_sync_monitor;

    localparam int unsigned HT = 10;
    localparam int unsigned HS = 3;
    localparam int unsigned HV = 6;
    localparam int unsigned VT = 8;
    localparam int unsigned VS = 2;
    localparam int unsigned VV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_n = 1'b1;
    logic       vs_n = 1'b1;
    logic       r_in = 1'b0;
    logic       g_in = 1'b0;
    logic       b_in = 1'b0;
    logic [9:0] pix_x, pix_y, line_len, frame_lines;
    logic       pix_valid, pix_r, pix_g, pix_b, frame_start, locked, err_pulse;
    logic [7:0] err_cnt;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_START(HS), .H_VIS(HV),
        .V_TOTAL(VT), .V_START(VS), .V_VIS(VV)
    ) dut (
        .clk(clk), .rst(rst), .hs_n(hs_n), .vs_n(vs_n),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Observation counters, written only by the monitor processes below.
    int   ps = 0;
    int   vs_falls = 0, last_vs_ps = 0, last_hs_ps = 0, r_pin_ps = 0;
    logic vs_pin_prev = 1'b1, hs_pin_prev = 1'b1;
    int   lock_rises = 0, lock_delta = 0, lock_vsf = 0;
    logic locked_prev = 1'b0, ep_prev = 1'b0;
    int   ep_rises = 0, ep_cycles = 0, ep_delta = 0;
    int   fs_cnt = 0, nvalid = 0, sumx = 0, sumy = 0, nz_inval = 0, gb_err = 0;
    int   r_hits = 0, r_bad = 0, r_delta = 0;

    always @(posedge clk) begin
        ps++;
        if (!vs_n && vs_pin_prev) begin
            vs_falls++;
            last_vs_ps = ps;
        end
        if (!hs_n && hs_pin_prev) last_hs_ps = ps;
        vs_pin_prev = vs_n;
        hs_pin_prev = hs_n;
        if (r_in) r_pin_ps = ps;
    end

    always @(negedge clk) begin
        if (locked && !locked_prev) begin
            lock_rises++;
            lock_delta = ps - last_vs_ps;
            lock_vsf   = vs_falls;
        end
        locked_prev = locked;
        if (err_pulse) ep_cycles++;
        if (err_pulse && !ep_prev) begin
            ep_rises++;
            ep_delta = ps - last_hs_ps;
        end
        ep_prev = err_pulse;
        if (frame_start) fs_cnt++;
        if (pix_valid) begin
            nvalid++;
            sumx += int'(pix_x);
            sumy += int'(pix_y);
            if (pix_g != pix_x[0] || pix_b != pix_y[0]) gb_err++;
        end else if (pix_x != 0 || pix_y != 0 || pix_r || pix_g || pix_b) begin
            nz_inval++;
        end
        if (pix_r) begin
            r_hits++;
            r_delta = ps - r_pin_ps;
            if (pix_x != 10'd2 || pix_y != 10'd3) r_bad++;
        end
    end

    task automatic drive_cycle(input logic h, input logic v, input logic r,
                               input logic g, input logic b);
        @(negedge clk);
        hs_n = h; vs_n = v; r_in = r; g_in = g; b_in = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // g marks odd visible columns, b marks odd visible rows; r only at (r_line, r_col).
    task automatic drive_frame(input int nlines, input int short_line,
                               input int r_line, input int r_col);
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == short_line) ? int'(HT) - 1 : int'(HT);
            for (int c = 0; c < len; c++) begin
                drive_cycle(c >= 2, l >= 2, (l == r_line) && (c == r_col),
                            (c % 2) == 0, (l % 2) == 1);
            end
        end
    endtask

    initial begin
        int vsf0, lr0, ep0, epc0, fs0, nv0, sx0, sy0, rh0, rb0;

        repeat (3) @(negedge clk);
        check("rst_locked", int'(locked), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_xy", int'(pix_x) + int'(pix_y), 0);
        check("rst_pix_rgb", int'(pix_r) + int'(pix_g) + int'(pix_b), 0);
        check("rst_line_len", int'(line_len), 0);
        check("rst_frame_lines", int'(frame_lines), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_pulses", int'(err_pulse) + int'(frame_start), 0);

        rst = 1'b0;
        idle(3);
        vsf0 = vs_falls; lr0 = lock_rises; fs0 = fs_cnt;
        drive_frame(VT, -1, -1, -1);
        check("no_lock_first_vs", int'(locked), 0);
        drive_frame(VT, -1, -1, -1);
        check("lock_rises", lock_rises - lr0, 1);
        check("lock_at_vs_edge", lock_vsf - vsf0, 2);
        check("lock_latency", lock_delta, 1);
        check("no_fs_on_lock_edge", fs_cnt - fs0, 0);
        check("line_len", int'(line_len), int'(HT));
        check("frame_lines", int'(frame_lines), int'(VT));

        fs0 = fs_cnt; nv0 = nvalid; sx0 = sumx; sy0 = sumy;
        drive_frame(VT, -1, -1, -1);
        check("valid_per_frame", nvalid - nv0, int'(HV * VV));
        check("sum_x", sumx - sx0, 75);
        check("sum_y", sumy - sy0, 60);
        check("frame_start_cnt", fs_cnt - fs0, 1);

        rh0 = r_hits; rb0 = r_bad;
        drive_frame(VT, -1, 5, 5);
        check("r_hits", r_hits - rh0, 1);
        check("r_misplaced", r_bad - rb0, 0);
        check("r_latency", r_delta, 1);

        ep0 = ep_rises; epc0 = ep_cycles;
        drive_frame(VT, 3, -1, -1);
        check("glitch_err_pulses", ep_rises - ep0, 1);
        check("glitch_pulse_width", ep_cycles - epc0, 1);
        check("glitch_pulse_at_hs", ep_delta, 1);
        check("glitch_err_cnt", int'(err_cnt), 1);
        check("glitch_unlocked", int'(locked), 0);
        lr0 = lock_rises;
        drive_frame(VT, -1, -1, -1);
        check("glitch_frame_not_counted", int'(locked), 0);
        drive_frame(VT, -1, -1, -1);
        check("relock_after_clean", int'(locked), 1);
        check("relock_rises", lock_rises - lr0, 1);

        drive_frame(VT - 1, -1, -1, -1);
        drive_frame(VT, -1, -1, -1);
        check("short_frame_err_cnt", int'(err_cnt), 2);
        check("short_frame_unlocked", int'(locked), 0);
        check("short_frame_lines", int'(frame_lines), int'(VT) - 1);
        drive_frame(VT, -1, -1, -1);
        check("short_frame_relock", int'(locked), 1);

        ep0 = ep_rises;
        idle(1100);
        check("idle_err_pulses", ep_rises - ep0, 1);
        check("idle_err_cnt", int'(err_cnt), 3);
        check("idle_unlocked", int'(locked), 0);

        drive_frame(VT, -1, -1, -1);
        ep0 = ep_rises;
        for (int i = 0; i < 300; i++) begin
            drive_frame(VT - 1, -1, -1, -1);
            drive_frame(VT, -1, -1, -1);
            if (i == 250) check("err_cnt_254", int'(err_cnt), 254);
            if (i == 251) check("err_cnt_255", int'(err_cnt), 255);
        end
        check("sat_err_pulses", ep_rises - ep0, 300);
        check("sat_err_cnt", int'(err_cnt), 255);

        drive_frame(VT, -1, -1, -1);
        drive_frame(3, -1, -1, -1);
        for (int c = 0; c < 7; c++) drive_cycle(c >= 2, 1'b1, 1'b0, (c % 2) == 0, 1'b1);
        check("locked_before_reset", int'(locked), 1);
        check("valid_before_reset", int'(pix_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_locked", int'(locked), 0);
        check("arst_pix_valid", int'(pix_valid), 0);
        check("arst_err_cnt", int'(err_cnt), 0);
        check("arst_lens", int'(line_len) + int'(frame_lines), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hs_n = 1'b1; vs_n = 1'b1; r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
        idle(3);
        vsf0 = vs_falls; lr0 = lock_rises;
        drive_frame(VT, -1, -1, -1);
        drive_frame(VT, -1, -1, -1);
        check("reacquire_locked", int'(locked), 1);
        check("reacquire_vs_edges", lock_vsf - vsf0, 2);
        check("reacquire_err_cnt", int'(err_cnt), 0);

        check("gb_alignment_errs", gb_err, 0);
        check("nonzero_while_invalid", nz_inval, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
